// File: rtl/fifo_pkg.sv
// Shared definitions so the write arbiter and the FIFO agree on geometry.
// Also holds the arbiter state encoding.
package fifo_pkg;
    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 64;
    localparam int FIFO_CW    = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter, bundled as one interface.
// The arbiter uses the slave view; the environment (producers plus FIFO) uses the master view.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int DW    = FIFO_DW,
    parameter int CW    = FIFO_CW
);
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC*DW-1:0] src_data;
    logic [N_SRC-1:0]    src_ready;
    logic                fifo_full;
    logic [CW-1:0]       fifo_count;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_din;
    logic [N_SRC-1:0]    grant;
    logic                busy;

    modport slave (
        input  src_valid, src_data, fifo_full, fifo_count,
        output src_ready, fifo_wr_en, fifo_din, grant, busy
    );

    modport master (
        output src_valid, src_data, fifo_full, fifo_count,
        input  src_ready, fifo_wr_en, fifo_din, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after i_ptr, searching upward with wrap.
// Purely combinational so it can also serve a future read-side scheduler.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win,
    output logic [PW-1:0] o_idx
);
    logic w_found;
    int   w_j;

    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap keeps non-power-of-2 N correct
            w_j = int'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_win[w_j] = 1'b1;
                o_idx      = PW'(w_j);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_SRC producers.
// A grant is issued only when the FIFO has room for a whole burst; a full FIFO stalls without releasing.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DW        = FIFO_DW,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int CW        = FIFO_CW,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BCW = $clog2(BURST_LEN + 1);

    arb_state_e       r_state,    w_state_next;
    logic [N_SRC-1:0] r_grant,    w_grant_next;
    logic [PW-1:0]    r_idx,      w_idx_next;
    logic [PW-1:0]    r_rr_ptr,   w_rr_ptr_next;
    logic [BCW-1:0]   r_beat_cnt, w_beat_cnt_next;

    logic [N_SRC-1:0] w_win;
    logic [PW-1:0]    w_win_idx;
    logic [CW:0]      w_free;
    logic             w_space;
    logic             w_sel_valid;
    logic             w_xfer;
    logic             w_exit;
    logic [DW-1:0]    w_slice [N_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_slice
            assign w_slice[gi] = bus.src_data[gi*DW +: DW];
        end
    endgenerate

    rr_pick #(
        .N  (N_SRC),
        .PW (PW)
    ) u_rr_pick (
        .i_req (bus.src_valid),
        .i_ptr (r_rr_ptr),
        .o_win (w_win),
        .o_idx (w_win_idx)
    );

    // one extra bit so a count of DEPTH still yields a correct zero
    assign w_free      = (CW+1)'(DEPTH) - {1'b0, bus.fifo_count};
    assign w_space     = (w_free >= (CW+1)'(BURST_LEN));
    assign w_sel_valid = bus.src_valid[r_idx];
    assign w_xfer      = (r_state == BURST) && w_sel_valid && !bus.fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_idx      <= w_idx_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_idx_next      = r_idx;
        w_rr_ptr_next   = r_rr_ptr;
        w_beat_cnt_next = r_beat_cnt;
        w_exit          = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|bus.src_valid) && w_space) begin
                    w_state_next    = BURST;
                    w_grant_next    = w_win;
                    w_idx_next      = w_win_idx;
                    w_beat_cnt_next = '0;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    if (r_beat_cnt == BCW'(BURST_LEN - 1)) begin
                        w_exit = 1'b1;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + 1'b1;
                    end
                end else if (!w_sel_valid) begin
                    // a valid drop ends the burst; the producer must re-arbitrate
                    w_exit = 1'b1;
                end
                if (w_exit) begin
                    w_state_next  = IDLE;
                    w_grant_next  = '0;
                    w_rr_ptr_next = (r_idx == PW'(N_SRC - 1)) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    assign bus.src_ready  = r_grant & {N_SRC{~bus.fifo_full}};
    assign bus.fifo_wr_en = |(bus.src_valid & bus.src_ready);
    assign bus.fifo_din   = bus.fifo_wr_en ? w_slice[r_idx] : '0;
    assign bus.grant      = r_grant;
    assign bus.busy       = (r_state == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producers are modelled as counters that advance on accepted beats,
// and every observed output is compared against hand-derived cycle tables.
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [3:0] cnt [4];
    int   nw;

    fifo_wr_arbiter_if #(.N_SRC(4), .DW(8), .CW(7)) bus ();

    fifo_wr_arbiter #(
        .N_SRC     (4),
        .DW        (8),
        .DEPTH     (64),
        .CW        (7),
        .BURST_LEN (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [3:0] g, input logic we,
                          input logic [7:0] d, input logic [3:0] rdy, input logic bsy);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
        chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'(we));
        chk({tag, "_din"},   32'(bus.fifo_din), 32'(d));
        chk({tag, "_ready"}, 32'(bus.src_ready), 32'(rdy));
        chk({tag, "_busy"},  32'(bus.busy), 32'(bsy));
    endtask

    task automatic upd_data();
        for (int i = 0; i < 4; i++) begin
            bus.src_data[i*8 +: 8] = 8'(8'h10 * (i + 1)) + 8'(cnt[i]);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // one clock: producers advance only on beats accepted at the edge
    task automatic cyc();
        logic [3:0] acc;
        @(negedge clk);
        acc = bus.src_valid & bus.src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) cnt[i] = cnt[i] + 1'b1;
        end
        upd_data();
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.src_valid  = '0;
        bus.fifo_full  = 1'b0;
        bus.fifo_count = '0;
        for (int i = 0; i < 4; i++) cnt[i] = '0;
        upd_data();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.src_valid  = 4'b1111;
        bus.fifo_full  = 1'b0;
        bus.fifo_count = '0;
        for (int i = 0; i < 4; i++) cnt[i] = '0;
        upd_data();
        #2;
        chk_st("reset", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

        // single source: two 4-beat bursts separated by one idle bubble
        do_reset();
        bus.src_valid = 4'b0001;
        settle();
        chk_st("t1_idle0", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        for (int r = 0; r < 2; r++) begin
            cyc();
            for (int k = 0; k < 4; k++) begin
                chk_st("t1_beat", 4'b0001, 1'b1, 8'(8'h10 + 4*r + k), 4'b0001, 1'b1);
                cyc();
            end
            chk_st("t1_gap", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        end
        bus.src_valid = 4'b0000;

        // all four valid from reset: rotation 0,1,2,3,0 and 16 words in 20 cycles
        do_reset();
        bus.src_valid = 4'b1111;
        settle();
        nw = 0;
        for (int b = 0; b < 5; b++) begin
            chk_st("t2_gap", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
            if (b > 0 && bus.fifo_wr_en) nw++;
            cyc();
            for (int k = 0; k < ((b < 4) ? 4 : 1); k++) begin
                chk_st("t2_beat", 4'(1 << (b % 4)), 1'b1,
                       8'(8'h10 * ((b % 4) + 1) + (b / 4) * 4 + k), 4'(1 << (b % 4)), 1'b1);
                if (b < 4 && bus.fifo_wr_en) nw++;
                cyc();
            end
        end
        chk("t2_words", 32'(nw), 32'd16);

        // full stall in the middle of a source-2 burst
        do_reset();
        bus.src_valid = 4'b0100;
        settle();
        chk_st("t3_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk_st("t3_beat", 4'b0100, 1'b1, 8'(8'h30 + k), 4'b0100, 1'b1);
            cyc();
        end
        bus.fifo_full = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk_st("t3_stall", 4'b0100, 1'b0, 8'h00, 4'b0000, 1'b1);
            cyc();
        end
        bus.fifo_full = 1'b0;
        settle();
        for (int k = 2; k < 4; k++) begin
            chk_st("t3_resume", 4'b0100, 1'b1, 8'(8'h30 + k), 4'b0100, 1'b1);
            cyc();
        end
        chk_st("t3_end", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        chk("t3_beats", 32'(cnt[2]), 32'd4);

        // space gating: 61 used leaves 3 free, too few for a burst of 4
        do_reset();
        bus.fifo_count = 7'd61;
        bus.src_valid  = 4'b0011;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("t4_busy_61", 32'(bus.busy), 32'd0);
            chk("t4_grant_61", 32'(bus.grant), 32'd0);
            cyc();
        end
        bus.fifo_count = 7'd60;
        settle();
        chk("t4_busy_60", 32'(bus.busy), 32'd0);
        cyc();
        chk_st("t4_start", 4'b0001, 1'b1, 8'h10, 4'b0001, 1'b1);

        // early release by source 1; pointer moves to 2 so source 3 beats source 0
        do_reset();
        bus.src_valid = 4'b0010;
        settle();
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk_st("t5_beat", 4'b0010, 1'b1, 8'(8'h20 + k), 4'b0010, 1'b1);
            cyc();
        end
        bus.src_valid = 4'b1001;
        settle();
        chk_st("t5_drop", 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1);
        cyc();
        chk_st("t5_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        cyc();
        chk_st("t5_src3", 4'b1000, 1'b1, 8'h40, 4'b1000, 1'b1);

        // asynchronous reset pulse during the second beat
        do_reset();
        bus.src_valid = 4'b1111;
        settle();
        cyc();
        chk_st("t6_beat0", 4'b0001, 1'b1, 8'h10, 4'b0001, 1'b1);
        cyc();
        chk_st("t6_beat1", 4'b0001, 1'b1, 8'h11, 4'b0001, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_st("t6_rst", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        rst_n = 1'b1;
        #1;
        cyc();
        chk_st("t6_regrant", 4'b0001, 1'b1, 8'h11, 4'b0001, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
